// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the CPU and external requesters, the arbiter and the
// single-port data memory. The arbiter connects through the slave modport.
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ack;
  logic [DW-1:0] ext_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  logic          gnt_cpu;
  logic          gnt_ext;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output gnt_cpu, gnt_ext
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  gnt_cpu, gnt_ext
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/external arbiter and access sequencer for the mips_16 data memory.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; default is fixed CPU priority.
module dmem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          owner_ext_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          mem_we_q;
  logic          mem_re_q;
  logic          cpu_ack_q;
  logic          ext_ack_q;
  logic          gnt_cpu_q;
  logic          gnt_ext_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ext_rdata_q;

  logic          win_ext_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

`ifdef DMEM_ARB_RR_EN
  logic          last_ext_q;

  // On a tie the port that did not win last time is served.
  always_comb win_ext_d = bus.ext_req & (~bus.cpu_req | ~last_ext_q);
`else
  always_comb win_ext_d = bus.ext_req & ~bus.cpu_req;
`endif

  always_comb begin
    we_d    = win_ext_d ? bus.ext_we    : bus.cpu_we;
    addr_d  = win_ext_d ? bus.ext_addr  : bus.cpu_addr;
    wdata_d = win_ext_d ? bus.ext_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_ext_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      gnt_cpu_q   <= 1'b0;
      gnt_ext_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_ext_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req | bus.ext_req) begin
            owner_ext_q <= win_ext_d;
            gnt_cpu_q   <= ~win_ext_d;
            gnt_ext_q   <= win_ext_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= CNT_INIT;
            mem_re_q    <= ~we_d;
            // A single-cycle access has its only BUSY cycle as the write cycle.
            mem_we_q    <= we_d & (CNT_INIT == 4'd0);
`ifdef DMEM_ARB_RR_EN
            last_ext_q  <= win_ext_d;
`endif
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cpu_ack_q <= ~owner_ext_q;
            ext_ack_q <= owner_ext_q;
            if (!we_q) begin
              if (owner_ext_q) ext_rdata_q <= bus.mem_rdata;
              else             cpu_rdata_q <= bus.mem_rdata;
            end
            state_q   <= DONE;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            mem_re_q <= ~we_q;
            mem_we_q <= we_q & (cnt_q == 4'd1);
          end
        end
        DONE: begin
          cpu_ack_q <= 1'b0;
          ext_ack_q <= 1'b0;
          gnt_cpu_q <= 1'b0;
          gnt_ext_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
  assign bus.ext_ack   = ext_ack_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.gnt_cpu   = gnt_cpu_q;
  assign bus.gnt_ext   = gnt_ext_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 16-bit data memory behind the mips_16 datapath.
- Shares the memory between the CPU load/store path and an external requester (loader/debug port).
- Each access is stretched over a programmable number of memory cycles.
- The CPU port provides a stall indication so the core holds the PC while its access is pending.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- ACCESS_CYCLES, 1, memory cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  AW  CPU address
- cpu_wdata  input  DW  CPU write data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  DW  CPU read data, registered
- cpu_stall  output  1  cpu_req & ~cpu_ack
- ext_req  input  1  external request, held until ext_ack
- ext_we  input  1  1 = write, 0 = read
- ext_addr  input  AW  external address
- ext_wdata  input  DW  external write data
- ext_ack  output  1  one-cycle completion pulse
- ext_rdata  output  DW  external read data, registered
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_we  output  1  memory write enable
- mem_re  output  1  memory read enable
- mem_rdata  input  DW  memory read data, valid while mem_re is high
- gnt_cpu  output  1  CPU owns the memory (BUSY/DONE)
- gnt_ext  output  1  external requester owns the memory

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset (rst low, any cycle, including mid-access):
  - state = IDLE; counter = 0.
  - All outputs 0; cpu_rdata = ext_rdata = 0.
  - last_winner = EXT.
  - An access aborted by reset is lost; no ack is ever issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's we/addr/wdata into internal registers.
  - Load counter = ACCESS_CYCLES-1, set owner, go to BUSY.
  - No req high: stay in IDLE.
- BUSY:
  - mem_addr and mem_wdata come from the latched registers.
  - Reads: mem_re = 1 for every BUSY cycle.
  - Writes: mem_we = 1 only in the final BUSY cycle (counter == 0), exactly one pulse per write.
  - counter decrements each cycle.
  - When counter == 0: on a read, capture mem_rdata into the owner's rdata register; go to DONE.
- DONE:
  - Owner's ack = 1 for exactly one cycle; the owner's rdata is valid from this cycle and held until that owner's next read completes.
  - mem_we = mem_re = 0.
  - Next state is IDLE.
- Outside BUSY, mem_addr/mem_wdata hold their last values; mem_we and mem_re are 0.
- Latency: req first seen in IDLE at cycle T → BUSY at T+1..T+ACCESS_CYCLES → ack at T+ACCESS_CYCLES+1.
- Throughput: one access per ACCESS_CYCLES+2 cycles.
- Requester rule: drop or re-issue req at the clock edge on which ack is sampled.
  - req must be low or carry a new request in the following IDLE cycle, so each access is served exactly once.
- Request inputs are sampled only in IDLE. Changes to addr/we/wdata during BUSY have no effect.
- A req withdrawn before it is granted is simply ignored.
- A req withdrawn after it is granted still completes; its ack is issued regardless.
- Tie (both req in IDLE): CPU wins.
- The losing requester waits; it is served in the next IDLE at the latest if it is the only one requesting.
- gnt_cpu and gnt_ext are registered, mutually exclusive, and high through BUSY and DONE.
- cpu_stall is combinational; it is 0 when cpu_req is 0.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: on a tie, the winner is the requester that is not last_winner. last_winner updates on every grant and resets to EXT, so the CPU wins the first tie.
  - Two continuously requesting ports therefore alternate CPU, EXT, CPU, ...
- Undefined: fixed CPU priority. last_winner is not implemented, and the external port can starve while the CPU requests continuously.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, then release with no req → all outputs 0 and state IDLE for 10 cycles.
- CPU write: ACCESS_CYCLES=3, cpu_req/cpu_we=1, cpu_addr=0x0010, cpu_wdata=0xBEEF → mem_we is a single pulse 3 cycles after grant at addr 0x0010; cpu_ack 4 cycles after req; cpu_stall high for 4 cycles.
- CPU read-back: cpu read of 0x0010 → cpu_rdata=0xBEEF with cpu_ack; ext_rdata unchanged.
- Tie: simultaneous cpu and ext writes, both held → CPU served first, then ext served with no lost access.
  - With DMEM_ARB_RR_EN, 4 back-to-back ties alternate CPU, EXT, CPU, EXT.
  - Without it, ext stays waiting until cpu_req drops.
- Reset mid-access: ACCESS_CYCLES=4, ext write, rst=0 in the 2nd BUSY cycle → no mem_we pulse and no ext_ack; after release the FSM is IDLE and a new cpu read completes normally.
- Input change during BUSY: change cpu_addr from 0x0020 to 0x0030 after grant → memory is accessed at 0x0020 only.
